obc_dft_bin_seq: RTL and testbench

Bit-serial sequencer for one OBC DFT output bin. It loads 16 two's-complement input samples and presents them to the 4-input OBC ROM/sign-correction datapath one bit-slice per cycle, MSB first. It runs two passes, m=0 for the real part and m=1 for the imaginary part, shift-accumulating the datapath's 32-bit partial sum. It sits between the sample buffer and the bin output register and is the only block that drives the datapath's bit and mode inputs.

---
 rtl/obc_dft_pkg.sv | 19 +
 rtl/obc_shift_acc.sv | 40 ++++
 rtl/obc_dft_bin_seq.sv | 161 ++++++++++++++++
 tb/tb_obc_dft_bin_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/obc_dft_pkg.sv
// Shared parameters and state encoding for the OBC DFT bin sequencer.
package obc_dft_pkg;

    localparam int W_DEF     = 8;
    localparam int ROM_W_DEF = 32;

    // Accumulator must hold the partial-sum width plus one bit per weighted slice.
    function automatic int acc_w(input int rom_w, input int w);
        return rom_w + w;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        RUN_RE,
        RUN_IM,
        DONE
    } state_t;

endpackage

// File: rtl/obc_shift_acc.sv
// Signed shift-accumulator: MSB slice loads -r, later slices apply acc*2 + r.
module obc_shift_acc #(
    parameter int ROM_W = 32,
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_clr_neg,
    input  logic                    i_step,
    input  logic signed [ROM_W-1:0] i_rom,
    output logic signed [ACC_W-1:0] o_acc,
    output logic signed [ACC_W-1:0] o_acc_nxt
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_r;

    assign w_r = {{(ACC_W-ROM_W){i_rom[ROM_W-1]}}, i_rom};

    always_comb begin
        o_acc_nxt = (r_acc <<< 1) + w_r;
        if (i_clr_neg) begin
            o_acc_nxt = -w_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= o_acc_nxt;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/obc_dft_bin_seq.sv
// Bit-serial sequencer for one OBC DFT bin: feeds MSB-first slices to the
// ROM datapath for a real then an imaginary pass and accumulates the results.
module obc_dft_bin_seq
    import obc_dft_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int ROM_W = ROM_W_DEF,
    parameter int ACC_W = acc_w(ROM_W, W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [16*W-1:0]         x_in,
    input  logic signed [ACC_W-1:0] off_re,
    input  logic signed [ACC_W-1:0] off_im,
    output logic [15:0]             x_bit,
    output logic                    m,
    input  logic signed [ROM_W-1:0] rom_in,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] re_out,
    output logic signed [ACC_W-1:0] im_out
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] B_MSB = CNT_W'(W - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]        r_bit;
    logic [16*W-1:0]         r_x;
    logic [15:0]             r_x_bit;
    logic                    r_m;
    logic signed [ACC_W-1:0] r_re_acc;
    logic signed [ACC_W-1:0] r_re_out;
    logic signed [ACC_W-1:0] r_im_out;

    logic                    w_last;
    logic                    w_accept;
    logic                    w_step;
    logic                    w_clr;
    logic                    w_clr_neg;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic signed [ACC_W-1:0] w_re_sum;
    logic signed [ACC_W-1:0] w_im_sum;

    function automatic logic [15:0] f_slice(input logic [16*W-1:0] x,
                                            input logic [CNT_W-1:0] b);
        logic [W-1:0] s;
        f_slice = '0;
        for (int unsigned n = 0; n < 16; n++) begin
            s          = x[n*W +: W];
            f_slice[n] = s[b];
        end
    endfunction

    assign w_last = (r_bit == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN_RE;
            RUN_RE:  if (w_last) w_state_nxt = RUN_IM;
            RUN_IM:  if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Offsets are sampled in DONE, so the result is combinational in that cycle
    // and held from the register afterwards.
    always_comb begin
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        w_accept  = (r_state == IDLE) && start;
        w_step    = (r_state == RUN_RE) || (r_state == RUN_IM);
        w_clr     = w_accept || ((r_state == RUN_RE) && w_last);
        w_clr_neg = (r_bit == B_MSB);
        re_out    = done ? w_re_sum : r_re_out;
        im_out    = done ? w_im_sum : r_im_out;
    end

    assign w_re_sum = r_re_acc + off_re;
    assign w_im_sum = w_acc + off_im;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit    <= '0;
            r_x      <= '0;
            r_x_bit  <= '0;
            r_m      <= 1'b0;
            r_re_acc <= '0;
            r_re_out <= '0;
            r_im_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x     <= x_in;
                        r_bit   <= B_MSB;
                        r_m     <= 1'b0;
                        r_x_bit <= f_slice(x_in, B_MSB);
                    end
                end
                RUN_RE: begin
                    if (w_last) begin
                        r_re_acc <= w_acc_nxt;
                        r_bit    <= B_MSB;
                        r_m      <= 1'b1;
                        r_x_bit  <= f_slice(r_x, B_MSB);
                    end else begin
                        r_bit   <= r_bit - 1'b1;
                        r_x_bit <= f_slice(r_x, r_bit - 1'b1);
                    end
                end
                RUN_IM: begin
                    if (w_last) begin
                        r_x_bit <= '0;
                    end else begin
                        r_bit   <= r_bit - 1'b1;
                        r_x_bit <= f_slice(r_x, r_bit - 1'b1);
                    end
                end
                DONE: begin
                    r_m      <= 1'b0;
                    r_re_out <= w_re_sum;
                    r_im_out <= w_im_sum;
                end
                default: ;
            endcase
        end
    end

    assign x_bit = r_x_bit;
    assign m     = r_m;

    obc_shift_acc #(
        .ROM_W(ROM_W),
        .ACC_W(ACC_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_clr_neg (w_clr_neg),
        .i_step    (w_step),
        .i_rom     (rom_in),
        .o_acc     (w_acc),
        .o_acc_nxt (w_acc_nxt)
    );

endmodule

// File: tb/tb_obc_dft_bin_seq.sv
// Directed bench for obc_dft_bin_seq with a popcount ROM datapath model.
module tb_obc_dft_bin_seq;

    localparam int W     = 8;
    localparam int ROM_W = 32;
    localparam int ACC_W = 40;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [16*W-1:0]         x_in;
    logic signed [ACC_W-1:0] off_re;
    logic signed [ACC_W-1:0] off_im;
    logic [15:0]             x_bit;
    logic                    m;
    logic signed [ROM_W-1:0] rom_in;
    logic                    busy;
    logic                    done;
    logic signed [ACC_W-1:0] re_out;
    logic signed [ACC_W-1:0] im_out;

    always #5 clk = ~clk;

    obc_dft_bin_seq #(
        .W     (W),
        .ROM_W (ROM_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x_in   (x_in),
        .off_re (off_re),
        .off_im (off_im),
        .x_bit  (x_bit),
        .m      (m),
        .rom_in (rom_in),
        .busy   (busy),
        .done   (done),
        .re_out (re_out),
        .im_out (im_out)
    );

    // Datapath model: popcount of the slice, negated in the imaginary pass when neg_im is set.
    logic neg_im;
    int   pc;
    always_comb begin
        pc     = $countones(x_bit);
        rom_in = (neg_im && m) ? ROM_W'(-pc) : ROM_W'(pc);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int                      cyc;
    int                      done_cnt;
    int                      dcyc [4];
    logic signed [ACC_W-1:0] dre;
    logic signed [ACC_W-1:0] dim;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            if (done_cnt < 4) dcyc[done_cnt] = cyc;
            if (done_cnt == 0) begin
                dre = re_out;
                dim = im_out;
            end
            done_cnt++;
        end
    endtask

    // Cycle c's start value is sampled at edge c; x_in is disturbed after capture.
    task automatic run(input logic [63:0] smask, input int ncyc, input bit chk_m);
        cyc      = 0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) dcyc[i] = -1;
        for (int c = 0; c < ncyc; c++) begin
            start = smask[c[5:0]];
            tick();
            if (c == 0 || c == 2) x_in = ~x_in;
            if (chk_m) begin
                if (cyc <= 16) check($sformatf("m@%0d", cyc), m, (cyc >= 9) ? 1 : 0);
                check($sformatf("busy@%0d", cyc), busy, (cyc <= 17) ? 1 : 0);
                if (cyc == 1)  check("xbit_msb", x_bit, 16'h0000);
                if (cyc == 8)  check("xbit_lsb", x_bit, 16'hFFFF);
                if (cyc == 16) check("xbit_im_lsb", x_bit, 16'hFFFF);
                if (cyc == 17) check("xbit_done", x_bit, 0);
            end
        end
        start = 1'b0;
    endtask

    task automatic single(input string tag, input logic [7:0] samp,
                          input int ore, input int oim, input int ere, input int eim);
        x_in   = {16{samp}};
        off_re = ACC_W'(ore);
        off_im = ACC_W'(oim);
        run(64'h1, 19, 1'b0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_cyc"}, dcyc[0], 17);
        check({tag, "_re"}, dre, ere);
        check({tag, "_im"}, dim, eim);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        x_in   = '0;
        off_re = '0;
        off_im = '0;
        neg_im = 1'b0;
        cyc    = 0;
        done_cnt = 0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("rst_re", re_out, 0);
        check("rst_im", im_out, 0);
        check("rst_xbit", x_bit, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_m", m, 0);

        // All samples 0x01, with per-cycle m/busy/x_bit profile
        x_in = {16{8'h01}};
        run(64'h1, 19, 1'b1);
        check("ones_done_cnt", done_cnt, 1);
        check("ones_done_cyc", dcyc[0], 17);
        check("ones_re", dre, 16);
        check("ones_im", dim, 16);
        check("ones_re_hold", re_out, 16);
        check("ones_im_hold", im_out, 16);
        check("ones_m_idle", m, 0);

        single("neg", 8'h80, 0, 0, -2048, -2048);
        single("m1", 8'hFF, 0, 0, -16, -16);
        neg_im = 1'b1;
        single("off", 8'h03, 5, -7, 53, -55);
        neg_im = 1'b0;

        // Starts at cycles 3 and 17 ignored, start at 18 accepted
        x_in   = {16{8'h01}};
        off_re = '0;
        off_im = '0;
        run(64'h60009, 40, 1'b0);
        check("dbl_done_cnt", done_cnt, 2);
        check("dbl_done1_cyc", dcyc[0], 17);
        check("dbl_done2_cyc", dcyc[1], 35);
        check("dbl_re", dre, 16);
        check("dbl_re_hold", re_out, 16);

        // Reset mid-run at cycle 6
        x_in = {16{8'hFF}};
        run(64'h1, 6, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_m", m, 0);
        check("abort_re", re_out, 0);
        check("abort_im", im_out, 0);
        check("abort_xbit", x_bit, 0);
        check("abort_done", done_cnt, 0);
        run(64'h0, 20, 1'b0);
        check("abort_no_done", done_cnt, 0);
        check("abort_busy_idle", busy, 0);

        x_in = {16{8'h01}};
        run(64'h1, 19, 1'b0);
        check("fresh_done_cnt", done_cnt, 1);
        check("fresh_done_cyc", dcyc[0], 17);
        check("fresh_re", dre, 16);
        check("fresh_im", dim, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
